// File: rtl/instruction_mem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory read port among per-warp fetchers.
// Optional IMEM_ARB_STATS_EN adds per-requester saturating grant counters (grant_count).
module instruction_mem_arbiter #(
    parameter int NUM_REQUESTERS = 4,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQUESTERS-1:0]           req_valid,
    input  logic [NUM_REQUESTERS*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQUESTERS-1:0]           req_ready,
    output logic [DATA_WIDTH-1:0]               req_data,
    output logic                                mem_read_valid,
    output logic [ADDR_WIDTH-1:0]               mem_read_address,
    input  logic                                mem_read_ready,
    input  logic [DATA_WIDTH-1:0]               mem_read_data,
    output logic [$clog2(NUM_REQUESTERS)-1:0]   grant_id,
    output logic                                busy
`ifdef IMEM_ARB_STATS_EN
    ,
    output logic [NUM_REQUESTERS*16-1:0]        grant_count
`endif
);

    localparam int GW = $clog2(NUM_REQUESTERS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        RESPOND = 2'd2
    } state_t;

    state_t                    state, state_next;
    logic [GW-1:0]             last_grant, last_grant_next;
    logic [GW-1:0]             grant_id_next;
    logic [NUM_REQUESTERS-1:0] req_ready_next;
    logic [DATA_WIDTH-1:0]     req_data_next;
    logic                      mem_read_valid_next;
    logic [ADDR_WIDTH-1:0]     mem_read_address_next;
    logic                      busy_next;
    logic [GW-1:0]             pick;

    // First requester at or after last+1, wrapping; descending scan lets the nearest one win.
    function automatic logic [GW-1:0] pick_next(input logic [NUM_REQUESTERS-1:0] req,
                                                 input logic [GW-1:0] last);
        logic [GW-1:0] sel;
        int            idx;
        sel = last;
        for (int k = NUM_REQUESTERS; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQUESTERS;
            if (req[idx]) sel = GW'(idx);
        end
        return sel;
    endfunction

    assign pick = pick_next(req_valid, last_grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next            = state;
        last_grant_next       = last_grant;
        grant_id_next         = grant_id;
        req_ready_next        = '0;
        req_data_next         = req_data;
        mem_read_valid_next   = mem_read_valid;
        mem_read_address_next = mem_read_address;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    grant_id_next         = pick;
                    mem_read_address_next = req_addr[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_read_valid_next   = 1'b1;
                    state_next            = REQUEST;
                end
            end
            REQUEST: begin
                // The grant is committed: req_valid/req_addr are no longer looked at.
                if (mem_read_ready) begin
                    req_data_next            = mem_read_data;
                    mem_read_valid_next      = 1'b0;
                    req_ready_next[grant_id] = 1'b1;
                    last_grant_next          = grant_id;
                    state_next               = RESPOND;
                end
            end
            RESPOND: begin
                state_next = IDLE;
            end
            default: begin
                mem_read_valid_next = 1'b0;
                state_next          = IDLE;
            end
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant       <= GW'(NUM_REQUESTERS - 1);
            grant_id         <= '0;
            req_ready        <= '0;
            req_data         <= '0;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            busy             <= 1'b0;
        end else begin
            last_grant       <= last_grant_next;
            grant_id         <= grant_id_next;
            req_ready        <= req_ready_next;
            req_data         <= req_data_next;
            mem_read_valid   <= mem_read_valid_next;
            mem_read_address <= mem_read_address_next;
            busy             <= busy_next;
        end
    end

`ifdef IMEM_ARB_STATS_EN
    logic [15:0] grant_cnt [NUM_REQUESTERS];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQUESTERS; i++) begin
            if (reset) begin
                grant_cnt[i] <= '0;
            end else if (req_ready[i]) begin
                grant_cnt[i] <= sat_inc(grant_cnt[i]);
            end
        end
    end

    for (genvar g = 0; g < NUM_REQUESTERS; g++) begin : g_cnt
        assign grant_count[g*16 +: 16] = grant_cnt[g];
    end
`endif

endmodule

// File: tb/tb_instruction_mem_arbiter.sv
// Self-checking bench for instruction_mem_arbiter: directed cases plus randomized traffic vs a round-robin model.
module tb_instruction_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   req_data;
    logic            mem_read_valid;
    logic [AW-1:0]   mem_read_address;
    logic            mem_read_ready;
    logic [DW-1:0]   mem_read_data;
    logic [1:0]      grant_id;
    logic            busy;
`ifdef IMEM_ARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    int cmp_count = 0;
    int err_count = 0;

    int            model_last;
    logic [AW-1:0] model_addr [N];

    always #5 clk = ~clk;

    instruction_mem_arbiter #(
        .NUM_REQUESTERS(N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_ready(req_ready),
        .req_data(req_data),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .grant_id(grant_id),
        .busy(busy)
`ifdef IMEM_ARB_STATS_EN
        ,
        .grant_count(grant_count)
`endif
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        cmp_count++;
        assert (obs === exp) else begin
            err_count++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a);
        req_valid[i]          = 1'b1;
        req_addr[i*AW +: AW]  = a;
        model_addr[i]         = a;
    endtask

    // Model: nearest pending requester after the last one served, wrapping around.
    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(model_last + k) % N]) return (model_last + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset          = 1'b1;
        req_valid      = '0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        tick();
        tick();
        reset      = 1'b0;
        model_last = N - 1;
    endtask

    task automatic run_txn(input int delay, input logic [DW-1:0] data,
                           input bit drop_early, input bit rereq);
        int            g;
        logic [AW-1:0] a;
        g = model_pick(req_valid);
        if (g < 0) begin
            chk("no_pending_request", 64'(req_valid), 64'(1));
            return;
        end
        a = model_addr[g];
        tick();
        chk("grant_id", 64'(grant_id), 64'(g));
        chk("mem_addr", 64'(mem_read_address), 64'(a));
        chk("mem_valid", 64'(mem_read_valid), 64'(1));
        chk("busy_req", 64'(busy), 64'(1));
        if (drop_early) begin
            for (int i = 0; i < N; i++) set_req(i, AW'($urandom));
            req_valid[g]         = 1'b0;
            req_addr[g*AW +: AW] = ~a;
        end
        for (int d = 0; d < delay; d++) begin
            tick();
            chk("stall_valid", 64'(mem_read_valid), 64'(1));
            chk("stall_addr", 64'(mem_read_address), 64'(a));
            chk("stall_grant", 64'(grant_id), 64'(g));
            chk("stall_ready", 64'(req_ready), 64'(0));
        end
        mem_read_ready = 1'b1;
        mem_read_data  = data;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = DW'($urandom);
        chk("req_ready_pulse", 64'(req_ready), 64'(1) << g);
        chk("req_data", 64'(req_data), 64'(data));
        chk("mem_valid_clr", 64'(mem_read_valid), 64'(0));
        model_last   = g;
        req_valid[g] = 1'b0;
        tick();
        chk("req_ready_end", 64'(req_ready), 64'(0));
        chk("busy_idle", 64'(busy), 64'(0));
        chk("req_data_hold", 64'(req_data), 64'(data));
        if (rereq) req_valid[g] = 1'b1;
    endtask

    initial begin
        reset          = 1'b0;
        req_valid      = '0;
        req_addr       = '0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        for (int i = 0; i < N; i++) model_addr[i] = '0;

        // Reset values
        do_reset();
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_req_data", 64'(req_data), 64'(0));
        chk("rst_mem_valid", 64'(mem_read_valid), 64'(0));
        chk("rst_mem_addr", 64'(mem_read_address), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
`ifdef IMEM_ARB_STATS_EN
        chk("rst_grant_count", 64'(grant_count), 64'(0));
`endif

        // Memory ready while idle is ignored
        mem_read_ready = 1'b1;
        mem_read_data  = 16'h1234;
        tick();
        mem_read_ready = 1'b0;
        chk("idle_mem_ready_ignored", 64'(req_ready), 64'(0));
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_req_data", 64'(req_data), 64'(0));

        // Single requester 2, immediate memory
        set_req(2, 8'h10);
        run_txn(0, 16'hABCD, 1'b0, 1'b0);
        chk("single_grant_id", 64'(grant_id), 64'(2));
        chk("single_data", 64'(req_data), 64'(16'hABCD));

        // All four requesting continuously: 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, AW'(8'h20 + i));
        for (int k = 0; k < 5; k++) begin
            run_txn(0, DW'($urandom), 1'b0, 1'b1);
            chk("rr_order", 64'(grant_id), 64'(k % N));
        end
        req_valid = '0;

        // Memory stall of 5 cycles
        set_req(3, 8'h77);
        run_txn(5, 16'h5A5A, 1'b0, 1'b0);

        // Requester 1 drops after grant while others start asking
        do_reset();
        set_req(1, 8'h42);
        run_txn(2, 16'hBEEF, 1'b1, 1'b0);
        chk("drop_grant_id", 64'(grant_id), 64'(1));
        run_txn(0, 16'h0F0F, 1'b0, 1'b0);
        chk("after_drop_next", 64'(grant_id), 64'(2));
        req_valid = '0;

        // Reset during REQUEST, then a late memory ready
        do_reset();
        set_req(3, 8'h5A);
        tick();
        chk("pre_rst_valid", 64'(mem_read_valid), 64'(1));
        reset = 1'b1;
        tick();
        reset          = 1'b0;
        req_valid      = '0;
        model_last     = N - 1;
        mem_read_ready = 1'b1;
        mem_read_data  = 16'hDEAD;
        tick();
        mem_read_ready = 1'b0;
        chk("abort_req_ready", 64'(req_ready), 64'(0));
        chk("abort_mem_valid", 64'(mem_read_valid), 64'(0));
        chk("abort_mem_addr", 64'(mem_read_address), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_grant", 64'(grant_id), 64'(0));
        chk("abort_req_data", 64'(req_data), 64'(0));
        tick();
        chk("abort_quiet", 64'(req_ready), 64'(0));

        // Randomized traffic
        set_req(0, 8'h01);
        set_req(3, 8'h03);
        run_txn(1, 16'h1111, 1'b0, 1'b0);
        chk("post_abort_first", 64'(grant_id), 64'(0));
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 1) == 1)) set_req(i, AW'($urandom));
            end
            if (req_valid == '0) set_req(int'($urandom_range(0, N - 1)), AW'($urandom));
            run_txn(int'($urandom_range(0, 3)), DW'($urandom), 1'b0, 1'b0);
        end
        req_valid = '0;

`ifdef IMEM_ARB_STATS_EN
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_req(0, AW'(k));
            run_txn(0, DW'($urandom), 1'b0, 1'b0);
        end
        set_req(3, 8'h33);
        run_txn(0, DW'($urandom), 1'b0, 1'b0);
        chk("cnt0", 64'(grant_count[0 +: 16]), 64'(3));
        chk("cnt1", 64'(grant_count[16 +: 16]), 64'(0));
        chk("cnt2", 64'(grant_count[32 +: 16]), 64'(0));
        chk("cnt3", 64'(grant_count[48 +: 16]), 64'(1));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule

// File: doc/instruction_mem_arbiter.md
# instruction_mem_arbiter

Shares one instruction-memory read port among `NUM_REQUESTERS` per-warp fetchers. Each fetcher raises a read request and holds it until it sees a one-cycle ready pulse. The arbiter grants requests round-robin, runs a single outstanding read to instruction memory, and returns the fetched word with a ready pulse to the granted fetcher. It sits between the fetchers of a compute core and the core's instruction-memory interface.

## Interface
Parameters:
- `NUM_REQUESTERS`, default 4: number of fetchers; must be ≥2.
- `ADDR_WIDTH`, default 8: instruction memory address width.
- `DATA_WIDTH`, default 16: instruction width; equals `INSTRUCTION_WIDTH`.

Ports:
- `clk`  in  1: clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  `NUM_REQUESTERS`: per-fetcher read request; held until the matching `req_ready` pulse.
- `req_addr`  in  `NUM_REQUESTERS*ADDR_WIDTH`: per-fetcher address; slice i is `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `req_ready`  out  `NUM_REQUESTERS`: one-hot, one-cycle completion pulse.
- `req_data`  out  `DATA_WIDTH`: returned instruction; valid while any `req_ready` bit is high, otherwise holds its last value.
- `mem_read_valid`  out  1: read request to instruction memory.
- `mem_read_address`  out  `ADDR_WIDTH`: read address.
- `mem_read_ready`  in  1: memory has data this cycle.
- `mem_read_data`  in  `DATA_WIDTH`: read data, sampled when `mem_read_ready` is 1.
- `grant_id`  out  `$clog2(NUM_REQUESTERS)`: index of the current or most recent grantee.
- `busy`  out  1: high in REQUEST and RESPOND.

## Operation
- Three-state FSM, all outputs registered.
- IDLE:
  - If any `req_valid` bit is set, select the first set bit scanning upward circularly from `last_grant+1`.
  - Latch `grant_id` and `mem_read_address = req_addr[grant]`, set `mem_read_valid=1`, and go to REQUEST.
  - Otherwise stay in IDLE.
- REQUEST:
  - Hold `mem_read_valid` and `mem_read_address` stable.
  - On `mem_read_ready=1`: capture `mem_read_data` into `req_data`, clear `mem_read_valid`, set `req_ready[grant_id]=1`, set `last_grant=grant_id`, and go to RESPOND.
- RESPOND:
  - Clear `req_ready` and go to IDLE.
  - The granted fetcher drops `req_valid` in this cycle, so IDLE never re-grants the same request.
- Once granted, a request is committed:
  - Deassertion of `req_valid` or a change of `req_addr` after the grant is ignored.
  - The ready pulse is still delivered.
- `mem_read_ready` is ignored in IDLE and RESPOND.
- An illegal state returns to IDLE.
- Reset values: state IDLE; `req_ready=0`; `req_data=0`; `mem_read_valid=0`; `mem_read_address=0`; `grant_id=0`; `busy=0`; `last_grant=NUM_REQUESTERS-1`, so requester 0 wins first.
- Reset mid-transaction aborts the read. No `req_ready` is issued, and a late `mem_read_ready` is ignored.

## Timing
- Request seen at edge E0 → `mem_read_valid` high from E0.
- Memory ready in the first REQUEST cycle → `req_ready` high for exactly one cycle starting at E1.
- Minimum request-to-ready latency is 2 cycles; each added memory wait cycle adds 1.
- Peak throughput is one transaction per 3 cycles (IDLE, REQUEST, RESPOND).
- Round-robin fairness: with all requesters continuously asserting, each is served once every `NUM_REQUESTERS` transactions. Worst-case wait is `NUM_REQUESTERS-1` transactions.
- Pointer wrap: after grant `NUM_REQUESTERS-1`, the scan starts at index 0.

## Configuration
- `IMEM_ARB_STATS_EN` defined:
  - Adds output `grant_count` (`NUM_REQUESTERS*16`), with one saturating 16-bit counter per requester.
  - The counter increments in the cycle its `req_ready` pulses, saturates at 16'hFFFF, and resets to 0.
- Undefined: the port and the counters are absent; all other behaviour is identical.

## Test plan
- Single requester 2 reads addr 8'h10, memory ready immediately, data 16'hABCD → `req_ready=4'b0100` for one cycle 2 cycles after request, `req_data=16'hABCD`, `grant_id=2`.
- All 4 request simultaneously after reset → grant order 0,1,2,3, then 0 again if re-requested; each `req_ready` is one-hot and a single cycle.
- Memory stalls 5 cycles → `mem_read_valid` and `mem_read_address` stay stable for 5 cycles, `req_ready` fires the cycle after `mem_read_ready`, and latency is 7 cycles.
- Requester 1 drops `req_valid` after being granted → its read still completes and `req_ready[1]` pulses; no other requester is granted meanwhile.
- `reset` asserted during REQUEST, then `mem_read_ready` pulsed → outputs at reset values, no `req_ready`, state IDLE.
- With `IMEM_ARB_STATS_EN` defined, 3 grants to requester 0 and 1 to requester 3 → `grant_count` slices = 3,0,0,1; a counter preloaded with 16'hFFFF stays at 16'hFFFF after another grant.
